parallel_to_serial_tx: RTL and testbench

Transmit-side serializer for the 10-bit symbol path. It accepts encoded symbols over a valid/ready handshake into a one-entry holding buffer and shifts them out LSB-first, one bit per Recovered_Bit_Clk. Bit 0 is sent first, so it lands in bit 0 of the receive-side 10-bit deserializer. The block applies optional polarity inversion, fills gaps with an idle symbol, supports electrical idle, and flags underruns.

---
 rtl/parallel_to_serial_tx_if.sv | 29 ++
 rtl/parallel_to_serial_tx.sv | 96 +++++++++
 tb/tb_parallel_to_serial_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/parallel_to_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : parallel_to_serial_tx_if
// Description : Valid/ready symbol handshake between a symbol producer and
//               the 10-bit serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface parallel_to_serial_tx_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] Tx_Data;
  logic                  Tx_Valid;
  logic                  Tx_Ready;

  // Producer side: presents symbols, observes buffer availability.
  modport master (
    output Tx_Data,
    output Tx_Valid,
    input  Tx_Ready
  );

  // Serializer side: consumes symbols, reports buffer availability.
  modport slave (
    input  Tx_Data,
    input  Tx_Valid,
    output Tx_Ready
  );
endinterface
`default_nettype wire

// File: rtl/parallel_to_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : parallel_to_serial_tx
// Description : LSB-first symbol serializer with a one-entry holding buffer,
//               idle-symbol gap fill, polarity inversion, electrical idle and
//               underrun flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_to_serial_tx #(
  parameter int                    DATA_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] IDLE_SYMBOL = 10'h17C
) (
  input  logic                          Recovered_Bit_Clk,
  input  logic                          Rst_n,
  parallel_to_serial_tx_if.slave        bus,
  input  logic                          TxPolarity,
  input  logic                          TxElecIdle,
  output logic                          Ser_out,
  output logic                          Sym_Start,
  output logic                          Underrun
);

  localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [0:0] ELEC_IDLE = 1'b0;
  localparam logic [0:0] SEND      = 1'b1;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_valid;

  // Holding buffer capture, bit shifting and symbol-boundary sequencing.
  // The accept path only fires when the buffer is empty and the boundary
  // load only fires when it is full, so the two never collide on hold_valid.
  always_ff @(posedge Recovered_Bit_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ELEC_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      Underrun   <= 1'b0;
    end else begin
      Underrun <= 1'b0;

      if (bus.Tx_Valid && !hold_valid) begin
        hold_reg   <= bus.Tx_Data;
        hold_valid <= 1'b1;
      end

      case (state)
        SEND: begin
          if (bit_cnt < LAST_BIT) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
          end else begin
            bit_cnt <= '0;
            if (TxElecIdle) begin
              // Held symbol stays buffered for when the link wakes up.
              state <= ELEC_IDLE;
            end else if (hold_valid) begin
              shift_reg  <= hold_reg;
              hold_valid <= 1'b0;
            end else begin
              shift_reg <= IDLE_SYMBOL;
              Underrun  <= 1'b1;
            end
          end
        end
        default: begin
          // Waking from electrical idle: idle fill here is not an underrun.
          if (!TxElecIdle) begin
            state   <= SEND;
            bit_cnt <= '0;
            if (hold_valid) begin
              shift_reg  <= hold_reg;
              hold_valid <= 1'b0;
            end else begin
              shift_reg <= IDLE_SYMBOL;
            end
          end
        end
      endcase
    end
  end

  // Outputs depend only on registers plus the static polarity control.
  assign bus.Tx_Ready = !hold_valid;
  assign Ser_out      = (state == SEND) ? (shift_reg[0] ^ TxPolarity) : 1'b0;
  assign Sym_Start    = (state == SEND) && (bit_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_parallel_to_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parallel_to_serial_tx
// Description : Randomized scoreboard bench for parallel_to_serial_tx with a
//               symbol-level reference model of the serial stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parallel_to_serial_tx;

  localparam int         DW   = 10;
  localparam logic [9:0] IDLE = 10'h17C;

  logic clk = 1'b0;
  logic Rst_n;
  logic TxPolarity;
  logic TxElecIdle;
  logic Ser_out;
  logic Sym_Start;
  logic Underrun;

  parallel_to_serial_tx_if #(.DATA_WIDTH(DW)) bus ();

  parallel_to_serial_tx #(.DATA_WIDTH(DW), .IDLE_SYMBOL(IDLE)) dut (
    .Recovered_Bit_Clk (clk),
    .Rst_n             (Rst_n),
    .bus               (bus),
    .TxPolarity        (TxPolarity),
    .TxElecIdle        (TxElecIdle),
    .Ser_out           (Ser_out),
    .Sym_Start         (Sym_Start),
    .Underrun          (Underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus controls
  int         base_p     = 0;
  logic       e_idle     = 1'b1;
  logic       pol        = 1'b0;
  logic       prev_ready = 1'b1;
  logic [9:0] dir_q[$];

  // Scoreboard: symbols the producer handed over, in order.
  logic [9:0] sym_q[$];

  // Reference model of the line
  logic in_send = 1'b0;
  logic held    = 1'b0;
  logic under   = 1'b0;
  logic bitq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic load_sym(input logic [9:0] s);
    bitq.delete();
    for (int i = 0; i < DW; i++) bitq.push_back(s[i]);
  endtask

  function automatic logic [9:0] next_held();
    if (sym_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      return 10'h000;
    end
    return sym_q.pop_front();
  endfunction

  // Monitor: advance the model at each edge and compare shortly after.
  initial begin : monitor
    logic cv, ce, rn, acc, b;
    forever begin
      @(posedge clk);
      cv = bus.Tx_Valid;
      ce = TxElecIdle;
      rn = Rst_n;
      if (!rn) begin
        in_send = 1'b0;
        held    = 1'b0;
        under   = 1'b0;
        bitq.delete();
        sym_q.delete();
      end else begin
        acc   = cv && !held;
        under = 1'b0;
        if (in_send) begin
          if (bitq.size() > 0) b = bitq.pop_front();
          if (bitq.size() == 0) begin
            if (ce) begin
              in_send = 1'b0;
            end else if (held) begin
              load_sym(next_held());
              held = 1'b0;
            end else begin
              load_sym(IDLE);
              under = 1'b1;
            end
          end
        end else if (!ce) begin
          in_send = 1'b1;
          if (held) begin
            load_sym(next_held());
            held = 1'b0;
          end else begin
            load_sym(IDLE);
          end
        end
        if (acc) held = 1'b1;
      end
      #1;
      check("ser_out",   Ser_out,   in_send ? (bitq[0] ^ TxPolarity) : 1'b0);
      check("sym_start", Sym_Start, in_send && (bitq.size() == DW));
      check("tx_ready",  bus.Tx_Ready, !held);
      check("underrun",  Underrun,  under);
    end
  end

  // One producer cycle: record an accepted symbol, then present new stimulus.
  task automatic drive_cycle();
    @(negedge clk);
    if (bus.Tx_Valid && prev_ready) begin
      sym_q.push_back(bus.Tx_Data);
      bus.Tx_Valid = 1'b0;
    end
    prev_ready = bus.Tx_Ready;
    if (!bus.Tx_Valid) begin
      if (dir_q.size() > 0) begin
        bus.Tx_Data  = dir_q.pop_front();
        bus.Tx_Valid = 1'b1;
      end else if ($urandom_range(0, 99) < base_p) begin
        bus.Tx_Data  = 10'($urandom);
        bus.Tx_Valid = 1'b1;
      end
    end
    TxElecIdle = e_idle;
    TxPolarity = pol;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  task automatic do_reset(input int n);
    drive_cycle();
    bus.Tx_Valid = 1'b0;
    dir_q.delete();
    Rst_n = 1'b0;
    #1;
    check("rst_ser_out",   Ser_out,      1'b0);
    check("rst_tx_ready",  bus.Tx_Ready, 1'b1);
    check("rst_sym_start", Sym_Start,    1'b0);
    check("rst_underrun",  Underrun,     1'b0);
    repeat (n) @(negedge clk);
    Rst_n      = 1'b1;
    prev_ready = 1'b1;
  endtask

  initial begin : stimulus
    Rst_n        = 1'b0;
    bus.Tx_Valid = 1'b0;
    bus.Tx_Data  = '0;
    TxElecIdle   = 1'b1;
    TxPolarity   = 1'b0;
    repeat (3) @(negedge clk);
    Rst_n = 1'b1;

    // Electrical idle persists after reset
    e_idle = 1'b1; base_p = 0;
    run(6);
    // Idle fill with underrun on every idle symbol after the first
    e_idle = 1'b0;
    run(35);
    // Back-to-back data
    dir_q.push_back(10'h2AA);
    dir_q.push_back(10'h155);
    run(30);
    // Single symbol followed by underrun
    dir_q.push_back(10'h0F0);
    run(30);
    // Polarity inversion
    pol = 1'b1;
    dir_q.push_back(10'h3FF);
    run(25);
    pol = 1'b0;
    // Electrical idle requested mid-symbol with a symbol held
    dir_q.push_back(10'h3C3);
    dir_q.push_back(10'h155);
    run(14);
    e_idle = 1'b1;
    run(20);
    e_idle = 1'b0;
    run(25);
    // Reset mid-stream with data in flight
    base_p = 100;
    run(13);
    do_reset(3);
    e_idle = 1'b1;
    run(4);
    e_idle = 1'b0;

    // Randomized segments
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 3))
        0:       base_p = 0;
        1:       base_p = 40;
        default: base_p = 100;
      endcase
      pol = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) do_reset($urandom_range(1, 4));
      for (int c = 0; c < $urandom_range(20, 80); c++) begin
        if ($urandom_range(0, 99) < 3) e_idle = !e_idle;
        drive_cycle();
      end
    end

    run(12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
